// File: rtl/multi_vc_circular_buffer.sv
// Per-VC input buffer: VC_NUM independent circular FIFOs behind one shared write port,
// with first-word-fall-through heads, hysteresis on/off flow control and sticky error flags.
module multi_vc_circular_buffer #(
  parameter int DATA_WIDTH  = 32,
  parameter int VC_NUM      = 2,
  parameter int BUFFER_SIZE = 8,
  parameter int OFF_LEVEL   = BUFFER_SIZE - 1,
  parameter int ON_LEVEL    = 1,
  localparam int VC_W  = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  localparam int PTR_W = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1,
  localparam int CNT_W = $clog2(BUFFER_SIZE + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        data_i,
  input  logic                         write_i,
  input  logic [VC_W-1:0]              write_vc_i,
  input  logic [VC_NUM-1:0]            read_i,
  output logic [VC_NUM*DATA_WIDTH-1:0] data_o,
  output logic [VC_NUM-1:0]            is_empty_o,
  output logic [VC_NUM-1:0]            is_full_o,
  output logic [VC_NUM-1:0]            on_off_o,
  output logic [VC_NUM*CNT_W-1:0]      count_o,
  output logic [VC_NUM-1:0]            overflow_o,
  output logic [VC_NUM-1:0]            underflow_o
);

  if (BUFFER_SIZE < 2) begin : g_bad_size
    $error("multi_vc_circular_buffer: BUFFER_SIZE must be >= 2");
  end
  if (ON_LEVEL >= OFF_LEVEL) begin : g_bad_levels
    $error("multi_vc_circular_buffer: ON_LEVEL must be below OFF_LEVEL");
  end
  if (OFF_LEVEL > BUFFER_SIZE) begin : g_bad_off
    $error("multi_vc_circular_buffer: OFF_LEVEL must not exceed BUFFER_SIZE");
  end

  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(BUFFER_SIZE - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(BUFFER_SIZE);
  localparam logic [CNT_W-1:0] OFF_CNT   = CNT_W'(OFF_LEVEL);
  localparam logic [CNT_W-1:0] ON_CNT    = CNT_W'(ON_LEVEL);

  // Wrap explicitly so non-power-of-two depths never index past the last entry.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
  endfunction

  for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
    logic [DATA_WIDTH-1:0] mem [BUFFER_SIZE];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_next;
    logic                  empty_q;
    logic                  full_q;
    logic                  on_off_q;
    logic                  on_off_next;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  wr_hit;
    logic                  wr_ok;
    logic                  rd_ok;

    // An out-of-range write_vc_i matches no VC, so it is dropped silently.
    assign wr_hit = write_i && (write_vc_i == VC_W'(v));
    assign rd_ok  = read_i[v] & ~empty_q;
    assign wr_ok  = wr_hit & (~full_q | rd_ok);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
      count_next = count;
      if (wr_ok && !rd_ok) begin
        count_next = count + CNT_W'(1);
      end else if (rd_ok && !wr_ok) begin
        count_next = count - CNT_W'(1);
      end
    end

    always_comb begin
      on_off_next = on_off_q;
      if (count_next >= OFF_CNT) begin
        on_off_next = 1'b0;
      end else if (count_next <= ON_CNT) begin
        on_off_next = 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        count       <= '0;
        empty_q     <= 1'b1;
        full_q      <= 1'b0;
        on_off_q    <= 1'b1;
        overflow_q  <= 1'b0;
        underflow_q <= 1'b0;
      end else begin
        if (wr_ok) wr_ptr <= ptr_inc(wr_ptr);
        if (rd_ok) rd_ptr <= ptr_inc(rd_ptr);
        count       <= count_next;
        empty_q     <= (count_next == '0);
        full_q      <= (count_next == FULL_CNT);
        on_off_q    <= on_off_next;
        overflow_q  <= overflow_q | (wr_hit & ~wr_ok);
        underflow_q <= underflow_q | (read_i[v] & empty_q);
      end
    end

    // NOTE: storage has no reset; validity is tracked by the pointers and count alone.
    always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= data_i;
    end

    assign data_o[v*DATA_WIDTH +: DATA_WIDTH] = mem[rd_ptr];
    assign count_o[v*CNT_W +: CNT_W]          = count;
    assign is_empty_o[v]                      = empty_q;
    assign is_full_o[v]                       = full_q;
    assign on_off_o[v]                        = on_off_q;
    assign overflow_o[v]                      = overflow_q;
    assign underflow_o[v]                     = underflow_q;
  end

endmodule

// File: tb/tb_multi_vc_circular_buffer.sv
// Bench for multi_vc_circular_buffer: default 2x8 instance plus a 3x5 instance for wrap checks.
module tb_multi_vc_circular_buffer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: VC_NUM=2, BUFFER_SIZE=8 (CNT_W=4, VC_W=1)
  logic [31:0] a_data;
  logic        a_write;
  logic [0:0]  a_vc;
  logic [1:0]  a_read;
  logic [63:0] a_data_o;
  logic [1:0]  a_empty, a_full, a_onoff, a_ovf, a_unf;
  logic [7:0]  a_count;

  // Instance B: VC_NUM=3, BUFFER_SIZE=5 (CNT_W=3, VC_W=2)
  logic [31:0] b_data;
  logic        b_write;
  logic [1:0]  b_vc;
  logic [2:0]  b_read;
  logic [95:0] b_data_o;
  logic [2:0]  b_empty, b_full, b_onoff, b_ovf, b_unf;
  logic [8:0]  b_count;

  multi_vc_circular_buffer #(.DATA_WIDTH(32), .VC_NUM(2), .BUFFER_SIZE(8)) dut_a (
    .clk(clk), .rst(rst), .data_i(a_data), .write_i(a_write), .write_vc_i(a_vc),
    .read_i(a_read), .data_o(a_data_o), .is_empty_o(a_empty), .is_full_o(a_full),
    .on_off_o(a_onoff), .count_o(a_count), .overflow_o(a_ovf), .underflow_o(a_unf)
  );

  multi_vc_circular_buffer #(.DATA_WIDTH(32), .VC_NUM(3), .BUFFER_SIZE(5)) dut_b (
    .clk(clk), .rst(rst), .data_i(b_data), .write_i(b_write), .write_vc_i(b_vc),
    .read_i(b_read), .data_o(b_data_o), .is_empty_o(b_empty), .is_full_o(b_full),
    .on_off_o(b_onoff), .count_o(b_count), .overflow_o(b_ovf), .underflow_o(b_unf)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] sb_a0[$];
  logic [31:0] sb_a1[$];
  logic [31:0] sb_b2[$];

  typedef struct {
    logic        wr;
    logic [31:0] d;
    logic        rd;
    logic [3:0]  cnt;
    logic        full;
    logic        empty;
    logic        onoff;
    logic        ovf;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Pops the expected head for queue q (0=A.vc0, 1=A.vc1, 2=B.vc2) and compares it.
  task automatic pop_check(input int q, input string name, input logic [31:0] act);
    logic [31:0] e;
    logic        ok;
    ok = 1'b1;
    e  = '0;
    case (q)
      0:       if (sb_a0.size() > 0) e = sb_a0.pop_front(); else ok = 1'b0;
      1:       if (sb_a1.size() > 0) e = sb_a1.pop_front(); else ok = 1'b0;
      default: if (sb_b2.size() > 0) e = sb_b2.pop_front(); else ok = 1'b0;
    endcase
    if (ok) begin
      check(name, {32'h0, act}, {32'h0, e});
    end else begin
      checks++;
      failures++;
      $display("FAIL %s: got 0x%0h expected scoreboard entry (queue empty)", name, act);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] a_cnt(input int v);
    return a_count[v*4 +: 4];
  endfunction
  function automatic logic [31:0] a_head(input int v);
    return a_data_o[v*32 +: 32];
  endfunction
  function automatic logic [2:0] b_cnt(input int v);
    return b_count[v*3 +: 3];
  endfunction
  function automatic logic [31:0] b_head(input int v);
    return b_data_o[v*32 +: 32];
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // Table for tests 1 and 2: 8 fills, one rejected write, 8 drains, all on VC1.
    for (int k = 0; k < 8; k++) begin
      vecs[k].wr    = 1'b1;
      vecs[k].d     = 32'h10 + 32'(k);
      vecs[k].rd    = 1'b0;
      vecs[k].cnt   = 4'(k + 1);
      vecs[k].full  = (k == 7);
      vecs[k].empty = 1'b0;
      vecs[k].onoff = (k + 1 < 7);
      vecs[k].ovf   = 1'b0;
    end
    vecs[8].wr    = 1'b1;
    vecs[8].d     = 32'h18;
    vecs[8].rd    = 1'b0;
    vecs[8].cnt   = 4'd8;
    vecs[8].full  = 1'b1;
    vecs[8].empty = 1'b0;
    vecs[8].onoff = 1'b0;
    vecs[8].ovf   = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      vecs[8+j].wr    = 1'b0;
      vecs[8+j].d     = 32'h0;
      vecs[8+j].rd    = 1'b1;
      vecs[8+j].cnt   = 4'(8 - j);
      vecs[8+j].full  = 1'b0;
      vecs[8+j].empty = (j == 8);
      vecs[8+j].onoff = (8 - j <= 1);
      vecs[8+j].ovf   = 1'b1;
    end

    rst = 1'b0;
    a_data = '0; a_write = 1'b0; a_vc = '0; a_read = '0;
    b_data = '0; b_write = 1'b0; b_vc = '0; b_read = '0;
    #12;
    check("rst a count", {56'h0, a_count}, 64'h0);
    check("rst a empty", {62'h0, a_empty}, 64'h3);
    check("rst a full",  {62'h0, a_full},  64'h0);
    check("rst a onoff", {62'h0, a_onoff}, 64'h3);
    check("rst a flags", {60'h0, a_ovf, a_unf}, 64'h0);
    check("rst b empty", {61'h0, b_empty}, 64'h7);
    check("rst b count", {55'h0, b_count}, 64'h0);
    rst = 1'b1;
    tick;

    // Tests 1-2: table-driven on VC1.
    for (int i = 0; i < 17; i++) begin
      a_write = vecs[i].wr;
      a_vc    = 1'b1;
      a_data  = vecs[i].d;
      a_read  = {vecs[i].rd, 1'b0};
      if (vecs[i].rd) pop_check(1, $sformatf("v%0d head1", i), a_head(1));
      if (vecs[i].wr && !vecs[i].ovf) sb_a1.push_back(vecs[i].d);
      tick;
      check($sformatf("v%0d cnt1", i),   {60'h0, a_cnt(1)},   {60'h0, vecs[i].cnt});
      check($sformatf("v%0d full1", i),  {63'h0, a_full[1]},  {63'h0, vecs[i].full});
      check($sformatf("v%0d empty1", i), {63'h0, a_empty[1]}, {63'h0, vecs[i].empty});
      check($sformatf("v%0d onoff1", i), {63'h0, a_onoff[1]}, {63'h0, vecs[i].onoff});
      check($sformatf("v%0d ovf1", i),   {63'h0, a_ovf[1]},   {63'h0, vecs[i].ovf});
      check($sformatf("v%0d vc0 idle", i), {59'h0, a_empty[0], a_cnt(0)}, 64'h10);
    end
    a_write = 1'b0; a_read = '0;

    // Test 3: full VC0 with simultaneous read + write.
    for (int i = 0; i < 8; i++) begin
      a_write = 1'b1; a_vc = 1'b0; a_data = 32'h20 + 32'(i);
      sb_a0.push_back(a_data);
      tick;
    end
    a_write = 1'b0;
    check("t3 cnt0 full", {60'h0, a_cnt(0)}, 64'h8);
    check("t3 full0", {63'h0, a_full[0]}, 64'h1);
    a_read = 2'b01; a_write = 1'b1; a_vc = 1'b0; a_data = 32'hAA;
    pop_check(0, "t3 rw head0", a_head(0));
    sb_a0.push_back(32'hAA);
    tick;
    a_write = 1'b0; a_read = '0;
    check("t3 cnt0 after rw", {60'h0, a_cnt(0)}, 64'h8);
    check("t3 ovf0", {63'h0, a_ovf[0]}, 64'h0);
    check("t3 full0 after rw", {63'h0, a_full[0]}, 64'h1);
    a_read = 2'b01;
    for (int i = 0; i < 8; i++) begin
      pop_check(0, $sformatf("t3 pop%0d head0", i), a_head(0));
      tick;
    end
    a_read = '0;
    check("t3 empty0", {63'h0, a_empty[0]}, 64'h1);
    check("t3 unf0", {63'h0, a_unf[0]}, 64'h0);

    // Test 4: empty VC0 with simultaneous read + write.
    a_read = 2'b01; a_write = 1'b1; a_vc = 1'b0; a_data = 32'h55;
    sb_a0.push_back(32'h55);
    tick;
    a_read = '0; a_write = 1'b0;
    check("t4 unf0", {63'h0, a_unf[0]}, 64'h1);
    check("t4 cnt0", {60'h0, a_cnt(0)}, 64'h1);
    check("t4 unf1 isolated", {63'h0, a_unf[1]}, 64'h0);
    a_read = 2'b01;
    pop_check(0, "t4 head0", a_head(0));
    tick;
    a_read = '0;
    check("t4 empty0", {63'h0, a_empty[0]}, 64'h1);

    // Test 5: non-power-of-two depth, pointer wrap on VC2 of instance B.
    for (int i = 0; i < 2; i++) begin
      b_write = 1'b1; b_vc = 2'd2; b_data = 32'h100 + 32'(i);
      sb_b2.push_back(b_data);
      tick;
    end
    for (int i = 0; i < 12; i++) begin
      b_write = 1'b1; b_vc = 2'd2; b_data = 32'h200 + 32'(i); b_read = 3'b100;
      pop_check(2, $sformatf("t5 pair%0d head2", i), b_head(2));
      sb_b2.push_back(b_data);
      tick;
      check($sformatf("t5 pair%0d cnt2", i), {61'h0, b_cnt(2)}, 64'h2);
    end
    b_write = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pop_check(2, $sformatf("t5 drain%0d head2", i), b_head(2));
      tick;
    end
    b_read = '0;
    check("t5 empty", {61'h0, b_empty}, 64'h7);
    b_write = 1'b1; b_vc = 2'd3; b_data = 32'hDEAD;
    tick;
    b_write = 1'b0;
    check("t5 vc3 count", {55'h0, b_count}, 64'h0);
    check("t5 vc3 ovf", {61'h0, b_ovf}, 64'h0);
    check("t5 vc3 empty", {61'h0, b_empty}, 64'h7);
    check("t5 vc3 onoff", {61'h0, b_onoff}, 64'h7);
    for (int i = 0; i < 6; i++) begin
      b_write = 1'b1; b_vc = 2'd2; b_data = 32'h300 + 32'(i);
      tick;
    end
    b_write = 1'b0;
    check("t5 fill cnt2", {61'h0, b_cnt(2)}, 64'h5);
    check("t5 fill full", {61'h0, b_full}, 64'h4);
    check("t5 fill onoff", {61'h0, b_onoff}, 64'h3);
    check("t5 fill ovf", {61'h0, b_ovf}, 64'h4);
    check("t5 wrapped head2", {32'h0, b_head(2)}, 64'h300);

    // Test 6: asynchronous reset mid-burst.
    for (int i = 0; i < 4; i++) begin
      a_write = 1'b1; a_vc = 1'b0; a_data = 32'h30 + 32'(i);
      tick;
    end
    a_vc = 1'b1; a_data = 32'h40;
    tick;
    a_write = 1'b0;
    check("t6 cnt0 pre", {60'h0, a_cnt(0)}, 64'h4);
    #2;
    rst = 1'b0;
    #1;
    sb_a0.delete(); sb_a1.delete(); sb_b2.delete();
    check("t6 async count", {56'h0, a_count}, 64'h0);
    check("t6 async empty", {62'h0, a_empty}, 64'h3);
    check("t6 async full",  {62'h0, a_full},  64'h0);
    check("t6 async onoff", {62'h0, a_onoff}, 64'h3);
    check("t6 async flags", {60'h0, a_ovf, a_unf}, 64'h0);
    check("t6 async b", {52'h0, b_ovf, b_full, b_empty, b_onoff}, 64'h3F);
    tick;
    tick;
    rst = 1'b1;
    a_write = 1'b1; a_vc = 1'b0; a_data = 32'h99;
    tick;
    a_write = 1'b0;
    check("t6 post cnt0", {60'h0, a_cnt(0)}, 64'h1);
    check("t6 post cnt1", {60'h0, a_cnt(1)}, 64'h0);
    check("t6 post head0", {32'h0, a_head(0)}, 64'h99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
